odelay_tap_stepper: RTL and testbench
=====================================

ODELAY_TAP_STEPPER -- requirements
Module: odelay_tap_stepper

Interface
REQ-001 Parameter INIT_TAP, default 0: tap loaded once after reset release, range 0..31.
REQ-002 Parameter SETTLE_CYCLES, default 4: idle cycles after each tap load before the next load, range 1..255.
REQ-003 Parameter MAX_TAP, default 31: highest permitted tap, range 0..31.
REQ-004 i_clk  input  1  sole clock, same clock as the ODELAY C pin (CLKDIV domain).
REQ-005 i_rst  input  1  asynchronous active-high reset.
REQ-006 i_req_valid  input  1  new target tap offered.
REQ-007 i_req_tap  input  5  requested target tap.
REQ-008 o_req_ready  output  1  block can accept a request this cycle.
REQ-009 o_ld  output  1  load strobe to the ODELAY LD pin.
REQ-010 o_cntvaluein  output  5  tap value to the ODELAY CNTVALUEIN pin.
REQ-011 o_tap  output  5  tap value most recently loaded.
REQ-012 o_delay_ps  output  12  nominal delay of o_tap in ps.
REQ-013 o_busy  output  1  high in every state except IDLE.
REQ-014 o_done  output  1  one-cycle pulse when a request completes.

Function
REQ-015 The FSM SHALL have the states INIT, IDLE, LOAD, SETTLE and DONE, with all outputs registered.
REQ-016 INIT (first cycle after reset release) SHALL drive o_ld=1 and o_cntvaluein=o_tap=INIT_TAP, then go to IDLE.
REQ-017 o_req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted only on the cycle where i_req_valid and o_req_ready are both 1.
REQ-018 The accepted target SHALL be latched as min(i_req_tap, MAX_TAP).
REQ-019 Target equal to o_tap: the next state SHALL be DONE, with no o_ld pulse.
REQ-020 Target different from o_tap: the next state SHALL be LOAD.
REQ-021 LOAD SHALL hold for exactly one cycle with o_ld=1 and o_cntvaluein=o_tap+1 (target above) or o_tap-1 (target below), and o_tap SHALL update to that value in the same cycle.
REQ-022 SETTLE SHALL hold for exactly SETTLE_CYCLES cycles with o_ld=0, then go to LOAD if o_tap differs from the target, else to DONE.
REQ-023 The tap SHALL change by exactly one per load, and o_tap SHALL never wrap below 0 or above MAX_TAP.
REQ-024 DONE SHALL hold for one cycle with o_done=1, then go to IDLE.
REQ-025 o_cntvaluein SHALL hold its last loaded value while o_ld=0.
REQ-026 o_delay_ps SHALL equal 600+78*o_tap, registered in the same cycle as o_tap (0 -> 600, 31 -> 3018).
REQ-027 i_req_valid and i_req_tap SHALL be ignored while o_req_ready=0 (no queuing).
REQ-028 Latency from acceptance at cycle T with N=|target-o_tap|>0: o_done SHALL be high at cycle T+N*(1+SETTLE_CYCLES)+1.
REQ-029 Latency for N=0: o_done SHALL be high at T+1.

Reset
REQ-030 While i_rst=1, regardless of edge: state=INIT (held), o_ld=0, o_cntvaluein=INIT_TAP, o_tap=INIT_TAP, o_delay_ps=600+78*INIT_TAP, o_req_ready=0, o_busy=1, o_done=0.
REQ-031 Reset asserted mid-sequence SHALL abandon the request without an o_done pulse, and the INIT load SHALL follow release.

Verification
REQ-032 Reset release, INIT_TAP=3 -> one-cycle o_ld=1 with o_cntvaluein=3, then o_req_ready=1, o_delay_ps=834.
REQ-033 From tap 5, request 8, SETTLE_CYCLES=4 -> o_ld pulses with 6, 7, 8 spaced 5 cycles apart; o_done at T+16; o_tap=8.
REQ-034 From tap 8, request 8 -> no o_ld; o_done at T+1.
REQ-035 From tap 2, request 0 -> o_ld pulses with 1 then 0; o_tap=0; no wrap to 31.
REQ-036 MAX_TAP=20, tap 19, request 31 -> single load of 20; o_done; o_tap=20.
REQ-037 i_rst asserted during SETTLE of a 0->10 request -> outputs at reset values immediately; no o_done; after release, o_tap=INIT_TAP and a new request is accepted.

Source files
------------

// File: rtl/odelay_tap_stepper.sv
// odelay_tap_stepper
//   Walks an ODELAY tap value toward a requested target one tap at a time.
//   Each step loads the new tap and then waits a fixed settle time before the
//   next step, so the delay line never jumps by more than one tap per load.
//   After reset release the block loads INIT_TAP once before it accepts any
//   request.
//
// Ports
//   i_clk         sole clock (ODELAY CLKDIV domain)
//   i_rst         asynchronous active-high reset
//   i_req_valid   new target tap offered
//   i_req_tap     requested target tap (clamped to MAX_TAP)
//   o_req_ready   request accepted this cycle if i_req_valid is also high
//   o_ld          load strobe to ODELAY LD
//   o_cntvaluein  tap value to ODELAY CNTVALUEIN (holds while o_ld is low)
//   o_tap         tap value most recently loaded
//   o_delay_ps    nominal delay of o_tap, 600 + 78*o_tap ps
//   o_busy        high in every state except IDLE
//   o_done        one-cycle pulse when a request completes
//
// State table
//   state  | meaning
//   INIT   | after reset: one cycle with o_ld=1 loading INIT_TAP, then IDLE
//   IDLE   | waiting for a request, o_req_ready=1
//   LOAD   | one-cycle load of o_tap +/- 1
//   SETTLE | SETTLE_CYCLES idle cycles after a load
//   DONE   | one-cycle o_done pulse
//
// Every output is a register; the output process computes the value each
// output takes in the next state so that the outputs line up with the state.

module odelay_tap_stepper #(
  parameter int INIT_TAP      = 0,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_TAP       = 31
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  input  logic [4:0]  i_req_tap,
  output logic        o_req_ready,
  output logic        o_ld,
  output logic [4:0]  o_cntvaluein,
  output logic [4:0]  o_tap,
  output logic [11:0] o_delay_ps,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [4:0]  INIT_TAP_V  = 5'(INIT_TAP);
  localparam logic [4:0]  MAX_TAP_V   = 5'(MAX_TAP);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [11:0] INIT_DELAY  = 12'(600 + 78 * INIT_TAP);

  state_t      state_q, state_d;
  logic [4:0]  target_q, target_d;
  logic [7:0]  settle_q, settle_d;
  logic        ld_q, ld_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  tap_q, tap_d;
  logic [11:0] delay_q, delay_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [4:0]  req_clamped;
  logic        accept;
  logic [4:0]  cmp_tap;
  logic [4:0]  step_tap;

  always_comb begin
    req_clamped = (i_req_tap > MAX_TAP_V) ? MAX_TAP_V : i_req_tap;
    accept      = i_req_valid & ready_q;
    // In IDLE the step direction comes from the incoming request, since the
    // target register has not been written yet.
    cmp_tap     = (state_q == S_IDLE) ? req_clamped : target_q;
    // LOAD is only entered when cmp_tap != tap_q and the target never
    // exceeds MAX_TAP, so neither direction can wrap.
    step_tap    = (cmp_tap > tap_q) ? (tap_q + 5'd1) : (tap_q - 5'd1);
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_INIT;
      target_q <= INIT_TAP_V;
      settle_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      settle_q <= settle_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    settle_d = settle_q;
    unique case (state_q)
      // ld_q low means the INIT load has not been issued yet; stay one more
      // cycle so the load is visible while the state still reads INIT.
      S_INIT: begin
        if (ld_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (accept) begin
          target_d = req_clamped;
          state_d  = (req_clamped == tap_q) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        state_d  = S_SETTLE;
        settle_d = SETTLE_LAST;
      end
      S_SETTLE: begin
        if (settle_q == 8'd0) begin
          state_d = (tap_q != target_q) ? S_LOAD : S_DONE;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    tap_d   = tap_q;
    ld_d    = 1'b0;
    if (state_d == S_LOAD) begin
      ld_d  = 1'b1;
      tap_d = step_tap;
    end else if (state_q == S_INIT && !ld_q) begin
      ld_d  = 1'b1;
    end
    cnt_d   = ld_d ? tap_d : cnt_q;
    delay_d = 12'd600 + 12'd78 * {7'd0, tap_d};
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // Output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ld_q    <= 1'b0;
      cnt_q   <= INIT_TAP_V;
      tap_q   <= INIT_TAP_V;
      delay_q <= INIT_DELAY;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
      tap_q   <= tap_d;
      delay_q <= delay_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_req_ready  = ready_q;
  assign o_ld         = ld_q;
  assign o_cntvaluein = cnt_q;
  assign o_tap        = tap_q;
  assign o_delay_ps   = delay_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_odelay_tap_stepper.sv
module tb_odelay_tap_stepper;

  localparam int INIT_TAP = 3;
  localparam int SETTLE   = 4;
  localparam int MAX_TAP  = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [4:0]  req_tap = 5'd0;
  logic        req_ready, ld, busy, done;
  logic [4:0]  cntvaluein, tap;
  logic [11:0] delay_ps;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int model_tap = INIT_TAP;
  logic [4:0] exp_q[$];

  odelay_tap_stepper #(
    .INIT_TAP(INIT_TAP), .SETTLE_CYCLES(SETTLE), .MAX_TAP(MAX_TAP)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_tap(req_tap),
    .o_req_ready(req_ready), .o_ld(ld), .o_cntvaluein(cntvaluein),
    .o_tap(tap), .o_delay_ps(delay_ps), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: every load strobe must match the next expected tap.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!rst && ld) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL ld_unexpected: got ld with cntvaluein=%0d, expected no load", cntvaluein);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if (cntvaluein !== e || tap !== e) begin
          bad++;
          $display("FAIL ld_value: got cntvaluein=%0d tap=%0d, expected %0d", cntvaluein, tap, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ld"}, int'(ld), 0);
    chk({tag, "_cnt"}, int'(cntvaluein), INIT_TAP);
    chk({tag, "_tap"}, int'(tap), INIT_TAP);
    chk({tag, "_delay"}, int'(delay_ps), 600 + 78 * INIT_TAP);
    chk({tag, "_ready"}, int'(req_ready), 0);
    chk({tag, "_busy"}, int'(busy), 1);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  // Waits for ready, offers one request and pushes the expected loads.
  // Returns the acceptance cycle; ok=0 if ready never came.
  task automatic offer(input int t, output int t_acc, output bit ok);
    int tgt, m;
    ok = 0;
    t_acc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    req_valid = 1'b1;
    req_tap   = 5'(t);
    t_acc     = cyc;
    tgt = (t > MAX_TAP) ? MAX_TAP : t;
    m = model_tap;
    while (m != tgt) begin
      m = (tgt > m) ? m + 1 : m - 1;
      exp_q.push_back(5'(m));
    end
    model_tap = tgt;
    @(posedge clk);
    #1;
    // Keep offering a different tap while busy; it must be ignored.
    req_tap = ~5'(t);
  endtask

  task automatic do_req(input string name, input int t, input int exp_tap, input int exp_n);
    int t_acc;
    bit ok, seen;
    offer(t, t_acc, ok);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (i > 0 || 1) @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    req_valid = 1'b0;
    if (!seen) begin
      chk({name, "_done_timeout"}, 0, 1);
      return;
    end
    chk({name, "_latency"}, cyc - t_acc, exp_n * (1 + SETTLE) + 1);
    chk({name, "_tap"}, int'(tap), exp_tap);
    chk({name, "_delay"}, int'(delay_ps), 600 + 78 * exp_tap);
    chk({name, "_loads_left"}, exp_q.size(), 0);
  endtask

  typedef struct {
    string name;
    int    req;
    int    exp_tap;
    int    exp_n;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int t_acc, d0;
    bit ok;

    vecs[0] = '{"up2",      5,  5,  2};
    vecs[1] = '{"up3",      8,  8,  3};
    vecs[2] = '{"same",     8,  8,  0};
    vecs[3] = '{"down6",    2,  2,  6};
    vecs[4] = '{"floor0",   0,  0,  2};
    vecs[5] = '{"up19",    19, 19, 19};
    vecs[6] = '{"clamp31", 31, 20,  1};
    vecs[7] = '{"same_max",20, 20,  0};
    vecs[8] = '{"clamp25", 25, 20,  0};

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");

    // Release: the INIT load of INIT_TAP comes first.
    exp_q.push_back(5'(INIT_TAP));
    rst = 1'b0;
    @(negedge clk);
    chk("init_ld", int'(ld), 1);
    chk("init_ready", int'(req_ready), 0);
    @(negedge clk);
    chk("init_ld_off", int'(ld), 0);
    chk("init_ready_on", int'(req_ready), 1);
    chk("init_delay", int'(delay_ps), 834);
    chk("init_busy", int'(busy), 0);

    foreach (vecs[i]) do_req(vecs[i].name, vecs[i].req, vecs[i].exp_tap, vecs[i].exp_n);

    // Walk down to 0, then interrupt a 0->10 request during SETTLE.
    do_req("to0", 0, 0, 20);
    offer(10, t_acc, ok);
    if (ok) begin
      while (cyc < t_acc + 3) @(negedge clk);
      d0 = done_cnt;
      rst = 1'b1;
      #1;
      chk_reset_vals("midrst");
      req_valid = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      model_tap = INIT_TAP;
      exp_q.push_back(5'(INIT_TAP));
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_no_done", done_cnt, d0);
      chk("midrst_tap", int'(tap), INIT_TAP);
      chk("midrst_loads_left", exp_q.size(), 0);
      do_req("after_rst", 6, 6, 3);
    end else begin
      req_valid = 1'b0;
    end

    repeat (5) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
